// File: rtl/coin_dispenser.sv
// coin_dispenser: greedy change-return engine driving a per-coin request/ack mechanism
module coin_dispenser #(
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] amount,
    input  logic       ack,
    output logic       disp_q,
    output logic       disp_d,
    output logic       disp_n,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] quarter_count,
    output logic [3:0] dime_count,
    output logic [3:0] nickel_count,
    output logic [6:0] remainder
);
    typedef enum logic [2:0] {IDLE, SELECT, DRIVE, GAP, DONE} state_t;

    state_t     state_q, state_d;
    logic [6:0] bal_q, bal_d, rem_q, rem_d;
    logic [7:0] tmo_q, tmo_d;
    logic [3:0] gap_q, gap_d, qcnt_q, qcnt_d, dcnt_q, dcnt_d, ncnt_q, ncnt_d;
    logic [2:0] coin_q, coin_d;
    logic       fault_q, fault_d;
    logic       tmo_hit, gap_end;
    logic [6:0] coin_val;

    assign tmo_hit  = tmo_q == 8'(TIMEOUT - 1);
    assign gap_end  = gap_q == 4'(GAP_CYCLES - 1);
    assign coin_val = coin_q[2] ? 7'd25 : coin_q[1] ? 7'd10 : 7'd5;

    // state and datapath registers; reset clears every visible output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bal_q   <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            qcnt_q  <= '0;
            dcnt_q  <= '0;
            ncnt_q  <= '0;
            coin_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bal_q   <= bal_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            qcnt_q  <= qcnt_d;
            dcnt_q  <= dcnt_d;
            ncnt_q  <= ncnt_d;
            coin_q  <= coin_d;
            fault_q <= fault_d;
        end
    end

    // next-state sequencing: pick coin, wait for ack or timeout, pause, repeat
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SELECT : IDLE;
            SELECT:  state_d = bal_q >= 7'd5 ? DRIVE : DONE;
            DRIVE:   state_d = ack ? GAP : tmo_hit ? DONE : DRIVE;
            GAP:     state_d = gap_end ? SELECT : GAP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath updates: balance, coin request, tallies, timers, fault, remainder
    always_comb begin
        bal_d   = bal_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        qcnt_d  = qcnt_q;
        dcnt_d  = dcnt_q;
        ncnt_d  = ncnt_q;
        coin_d  = coin_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: if (start) begin
                bal_d   = amount;
                rem_d   = '0;
                qcnt_d  = '0;
                dcnt_d  = '0;
                ncnt_d  = '0;
                fault_d = 1'b0;
            end
            SELECT: begin
                tmo_d  = '0;
                coin_d = {bal_q >= 7'd25, bal_q < 7'd25 && bal_q >= 7'd10, bal_q < 7'd10 && bal_q >= 7'd5};
                rem_d  = bal_q < 7'd5 ? bal_q : rem_q;
            end
            DRIVE: if (ack) begin
                coin_d = '0;
                gap_d  = '0;
                bal_d  = bal_q - coin_val;
                qcnt_d = qcnt_q + {3'd0, coin_q[2]};
                dcnt_d = dcnt_q + {3'd0, coin_q[1]};
                ncnt_d = ncnt_q + {3'd0, coin_q[0]};
            end else begin
                tmo_d   = tmo_q + 8'd1;
                coin_d  = tmo_hit ? 3'b000 : coin_q;
                fault_d = fault_q | tmo_hit;
                rem_d   = tmo_hit ? bal_q : rem_q;
            end
            GAP: gap_d = gap_q + 4'd1;
            default: ;
        endcase
    end

    // outputs decoded from registered state only
    always_comb begin
        busy                     = state_q != IDLE;
        done                     = state_q == DONE;
        {disp_q, disp_d, disp_n} = coin_q;
        fault                    = fault_q;
        quarter_count            = qcnt_q;
        dime_count               = dcnt_q;
        nickel_count             = ncnt_q;
        remainder                = rem_q;
    end
endmodule
